// File: rtl/jk_register_counter.sv
// WIDTH-bit JK register bank that doubles as a synchronous up/down counter,
// with parallel load, enable, terminal count and a registered change pulse.
// Optional build macro: JKREG_SATURATE_EN (counters hold at their end value instead of wrapping).
module jk_register_counter #(
  parameter int          WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CHG
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [WIDTH-1:0] RESET_Q = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] q;
  logic             chg;
  logic [WIDTH-1:0] q_next;
  logic             tc;

  // Counting reuses the JK toggle path: bit i toggles when every lower bit is 1.
  function automatic logic [WIDTH-1:0] up_toggles(input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] t;
    t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & cur[i-1];
    end
    return t;
  endfunction

  // Down counting toggles bit i when every lower bit is 0.
  function automatic logic [WIDTH-1:0] down_toggles(input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] t;
    t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & ~cur[i-1];
    end
    return t;
  endfunction

  // Standard JK characteristic equation, applied bitwise.
  function automatic logic [WIDTH-1:0] jk_next(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] jv,
    input logic [WIDTH-1:0] kv
  );
    return (jv & ~cur) | (~kv & cur);
  endfunction

  // Next-state selection: LOAD beats EN, EN beats MODE.
  always_comb begin
    q_next = q;
    if (LOAD) begin
      q_next = D;
    end else if (!EN) begin
      q_next = q;
    end else begin
      case (MODE)
        MODE_JK: q_next = jk_next(q, J, K);
        MODE_UP: begin
`ifdef JKREG_SATURATE_EN
          if (&q) begin
            q_next = q;
          end else begin
            q_next = q ^ up_toggles(q);
          end
`else
          q_next = q ^ up_toggles(q);
`endif
        end
        MODE_DOWN: begin
`ifdef JKREG_SATURATE_EN
          if (~|q) begin
            q_next = q;
          end else begin
            q_next = q ^ down_toggles(q);
          end
`else
          q_next = q ^ down_toggles(q);
`endif
        end
        MODE_HOLD: q_next = q;
        default:   q_next = q;
      endcase
    end
  end

  // State and change-pulse registers; reset acts immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q   <= RESET_Q;
      chg <= 1'b0;
    end else begin
      q   <= q_next;
      chg <= (q_next != q);
    end
  end

  // Terminal count looks only at Q and MODE, never at EN.
  always_comb begin
    tc = 1'b0;
    case (MODE)
      MODE_UP:   tc = &q;
      MODE_DOWN: tc = ~|q;
      MODE_JK:   tc = 1'b0;
      MODE_HOLD: tc = 1'b0;
      default:   tc = 1'b0;
    endcase
  end

  assign Q   = q;
  assign TC  = tc;
  assign CHG = chg;

endmodule

// File: tb/tb_jk_register_counter.sv
// Self-checking bench for jk_register_counter (WIDTH=4): directed test-plan
// scenarios plus randomized traffic against an arithmetic reference model.
module tb_jk_register_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] d = 4'h0;
  logic [3:0] j = 4'h0;
  logic [3:0] k = 4'h0;
  logic [3:0] q;
  logic       tc;
  logic       chg;

  int checks = 0;
  int errors = 0;

  // reference model state
  int exp_q = 0;
  bit exp_chg = 1'b0;

  jk_register_counter #(.WIDTH(4), .RESET_VALUE(0)) dut (
    .CLK(clk), .RESET(rst), .EN(en), .LOAD(load), .MODE(mode),
    .D(d), .J(j), .K(k), .Q(q), .TC(tc), .CHG(chg)
  );

  always #5 clk = ~clk;

  function automatic int model_next(int cur, bit en_v, bit load_v, int mode_v,
                                    int d_v, int j_v, int k_v);
    int n;
    if (load_v) return d_v;
    if (!en_v) return cur;
    case (mode_v)
      0: begin
        n = 0;
        for (int b = 0; b < 4; b++) begin
          bit jb, kb, qb, nb;
          jb = j_v[b]; kb = k_v[b]; qb = cur[b];
          if (!jb && !kb) nb = qb;
          else if (!jb && kb) nb = 1'b0;
          else if (jb && !kb) nb = 1'b1;
          else nb = !qb;
          n = n | (int'(nb) << b);
        end
        return n;
      end
`ifdef JKREG_SATURATE_EN
      1: return (cur == 15) ? cur : cur + 1;
      2: return (cur == 0) ? cur : cur - 1;
`else
      1: return (cur + 1) % 16;
      2: return (cur + 15) % 16;
`endif
      default: return cur;
    endcase
  endfunction

  function automatic bit model_tc(int cur, int mode_v);
    return (mode_v == 1 && cur == 15) || (mode_v == 2 && cur == 0);
  endfunction

  // Drive one cycle of inputs, advance the model, step past the edge.
  task automatic apply(input bit en_v, input bit load_v, input logic [1:0] mode_v,
                       input logic [3:0] d_v, input logic [3:0] j_v, input logic [3:0] k_v);
    int n;
    en = en_v; load = load_v; mode = mode_v; d = d_v; j = j_v; k = k_v;
    n = model_next(exp_q, en_v, load_v, int'(mode_v), int'(d_v), int'(j_v), int'(k_v));
    exp_chg = (n != exp_q);
    exp_q = n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #23;
    checks++;
    if (q !== 4'h0) begin errors++; $display("FAIL reset_q: got %h want 0", q); end
    checks++;
    if (chg !== 1'b0) begin errors++; $display("FAIL reset_chg: got %b want 0", chg); end
    rst = 1'b0;
    exp_q = 0; exp_chg = 1'b0;
    #1;
  endtask

  task automatic test_jk();
    apply(1'b1, 1'b1, 2'b00, 4'b0101, 4'h0, 4'h0);
    checks++;
    if (q !== 4'b0101) begin errors++; $display("FAIL jk_preload: got %b want 0101", q); end
    apply(1'b1, 1'b0, 2'b00, 4'h0, 4'b0011, 4'b0110);
    checks++;
    if (q !== 4'b0011) begin errors++; $display("FAIL jk_table: got %b want 0011", q); end
    checks++;
    if (chg !== 1'b1) begin errors++; $display("FAIL jk_chg: got %b want 1", chg); end
  endtask

  task automatic test_up_wrap();
    logic [3:0] want [3];
`ifdef JKREG_SATURATE_EN
    want = '{4'b1111, 4'b1111, 4'b1111};
`else
    want = '{4'b1111, 4'b0000, 4'b0001};
`endif
    apply(1'b1, 1'b1, 2'b01, 4'b1110, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);
      checks++;
      if (q !== want[i]) begin errors++; $display("FAIL up_wrap_q[%0d]: got %b want %b", i, q, want[i]); end
      if (i == 0) begin
        checks++;
        if (tc !== 1'b1) begin errors++; $display("FAIL up_wrap_tc: got %b want 1", tc); end
      end
`ifdef JKREG_SATURATE_EN
      if (i > 0) begin
        checks++;
        if (chg !== 1'b0) begin errors++; $display("FAIL up_sat_chg[%0d]: got %b want 0", i, chg); end
      end
`endif
    end
  endtask

  task automatic test_down_wrap();
    apply(1'b1, 1'b1, 2'b10, 4'b0001, 4'h0, 4'h0);
    apply(1'b1, 1'b0, 2'b10, 4'h0, 4'h0, 4'h0);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL down_q0: got %b want 0000", q); end
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL down_tc0: got %b want 1", tc); end
    apply(1'b1, 1'b0, 2'b10, 4'h0, 4'h0, 4'h0);
`ifdef JKREG_SATURATE_EN
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL down_sat_q: got %b want 0000", q); end
`else
    checks++;
    if (q !== 4'b1111) begin errors++; $display("FAIL down_wrap_q: got %b want 1111", q); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL down_wrap_tc: got %b want 0", tc); end
`endif
  endtask

  task automatic test_priority();
    apply(1'b0, 1'b1, 2'b01, 4'b1010, 4'hF, 4'hF);
    checks++;
    if (q !== 4'b1010) begin errors++; $display("FAIL prio_load: got %b want 1010", q); end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 2'b01, 4'b0101, 4'hF, 4'hF);
      checks++;
      if (q !== 4'b1010 || chg !== 1'b0) begin
        errors++; $display("FAIL prio_hold[%0d]: got q=%b chg=%b want q=1010 chg=0", i, q, chg);
      end
    end
  endtask

  task automatic test_hold();
    logic [3:0] start;
    start = q;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 2'b11, 4'h5, 4'hF, 4'hF);
      checks++;
      if (q !== start || chg !== 1'b0 || tc !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: got q=%b chg=%b tc=%b want q=%b chg=0 tc=0", i, q, chg, tc, start);
      end
    end
  endtask

  task automatic test_async_reset();
    apply(1'b1, 1'b1, 2'b01, 4'b0101, 4'h0, 4'h0);
    apply(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);
    checks++;
    if (q !== 4'b0110) begin errors++; $display("FAIL areset_pre: got %b want 0110", q); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'b0000 || chg !== 1'b0) begin
      errors++; $display("FAIL areset_now: got q=%b chg=%b want q=0000 chg=0", q, chg);
    end
    exp_q = 0; exp_chg = 1'b0;
    #1 rst = 1'b0;
    apply(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);
    checks++;
    if (q !== 4'b0001) begin errors++; $display("FAIL areset_after: got %b want 0001", q); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bit e, l;
      logic [1:0] m;
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 7) == 0);
      m = 2'($urandom_range(0, 3));
      apply(e, l, m, 4'($urandom), 4'($urandom), 4'($urandom));
      checks++;
      if (q !== 4'(exp_q) || chg !== exp_chg || tc !== model_tc(exp_q, int'(m))) begin
        errors++;
        $display("FAIL random[%0d]: got q=%h chg=%b tc=%b want q=%h chg=%b tc=%b",
                 i, q, chg, tc, 4'(exp_q), exp_chg, model_tc(exp_q, int'(m)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_jk();
    test_up_wrap();
    test_down_wrap();
    test_priority();
    test_hold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
